uart_tx_framer: RTL and testbench

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

---
 rtl/uart_tx_framer.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: UART transmit framer.
// Pops one word from a TX FIFO per frame, then serialises it:
// start bit, 5..9 data bits LSB first, optional even parity, then one or two stop bits.
// Frame settings are captured when the word is accepted.
// txd, busy and frame_done are registered.
// tx_ready is combinational, so the FIFO pop happens in the same cycle.
// Optional feature: define UART_TX_BREAK_EN to add the send_break input and the BREAK state.
// While in BREAK the line is held low.
// After BREAK the line is held high for one bit period before returning to IDLE.
module uart_tx_framer #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] divider,
  input  logic [4:0]       frame_len,
  input  logic             parity,
  input  logic             dstop,
  input  logic             flow_control,
  input  logic             cts_n,
  input  logic [8:0]       tx_data,
  input  logic             tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic             send_break,
`endif
  output logic             tx_ready,
  output logic             txd,
  output logic             busy,
  output logic             frame_done
);

  // The single DATA state walks D1..Dn using bit_idx_q as the data-bit index.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DSTOP  = 3'd5
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK    = 3'd6,
    S_BRK_STOP = 3'd7
`endif
  } state_t;

  // Limit the requested data-bit count to the supported range of 5..9.
  function automatic logic [3:0] clamp_len(input logic [4:0] len);
    logic [3:0] r;
    if (len < 5'd5) begin
      r = 4'd5;
    end else if (len > 5'd9) begin
      r = 4'd9;
    end else begin
      r = len[3:0];
    end
    return r;
  endfunction

  // Zero the payload bits above the frame length.
  // This lets the parity bit be a plain XOR of the whole stored word.
  function automatic logic [8:0] mask_data(input logic [8:0] d, input logic [3:0] n);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) begin
      if (i < int'(n)) begin
        r[i] = d[i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  // Even-parity bit over the (already masked) payload.
  function automatic logic even_parity(input logic [8:0] d);
    return ^d;
  endfunction

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       len_q, len_d;
  logic [8:0]       data_q, data_d;
  logic             par_en_q, par_en_d;
  logic             dstop_q, dstop_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;

  logic             tx_ready_s;
  logic             accept_s;
  logic             bit_done_s;

  assign bit_done_s = (cnt_q == div_q);
  assign accept_s   = tx_valid && tx_ready_s;

  // FIFO pop permission.
  // Requires IDLE, enable set, and (when flow control is on) cts_n low.
  // Suppressed while reset is asserted.
  always_comb begin
    tx_ready_s = 1'b0;
    if (rst_n && (state_q == S_IDLE) && enable && (!flow_control || !cts_n)) begin
      tx_ready_s = 1'b1;
`ifdef UART_TX_BREAK_EN
      if (send_break) begin
        tx_ready_s = 1'b0;
      end else begin
        tx_ready_s = 1'b1;
      end
`endif
    end else begin
      tx_ready_s = 1'b0;
    end
  end

  // Next state, bit timer, and capture of the frame word and settings.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + DIV_W'(1);
    bit_idx_d = bit_idx_q;
    len_d     = len_q;
    data_d    = data_q;
    div_d     = div_q;
    par_en_d  = par_en_q;
    dstop_d   = dstop_q;
    case (state_q)
      S_IDLE: begin
        cnt_d     = {DIV_W{1'b0}};
        bit_idx_d = 4'd0;
        if (accept_s) begin
          state_d  = S_START;
          len_d    = clamp_len(frame_len);
          data_d   = mask_data(tx_data, clamp_len(frame_len));
          div_d    = divider;
          par_en_d = parity;
          dstop_d  = dstop;
        end
`ifdef UART_TX_BREAK_EN
        else if (send_break) begin
          state_d = S_BREAK;
          div_d   = divider;
        end
`endif
        else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_done_s) begin
          state_d   = S_DATA;
          cnt_d     = {DIV_W{1'b0}};
          bit_idx_d = 4'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (bit_done_s) begin
          cnt_d = {DIV_W{1'b0}};
          if (bit_idx_q == (len_q - 4'd1)) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_done_s) begin
          state_d = S_STOP;
          cnt_d   = {DIV_W{1'b0}};
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (bit_done_s) begin
          state_d = dstop_q ? S_DSTOP : S_IDLE;
          cnt_d   = {DIV_W{1'b0}};
        end else begin
          state_d = S_STOP;
        end
      end
      S_DSTOP: begin
        if (bit_done_s) begin
          state_d = S_IDLE;
          cnt_d   = {DIV_W{1'b0}};
        end else begin
          state_d = S_DSTOP;
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        cnt_d = {DIV_W{1'b0}};
        if (!send_break) begin
          state_d = S_BRK_STOP;
        end else begin
          state_d = S_BREAK;
        end
      end
      S_BRK_STOP: begin
        if (bit_done_s) begin
          state_d = S_IDLE;
          cnt_d   = {DIV_W{1'b0}};
        end else begin
          state_d = S_BRK_STOP;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        cnt_d   = {DIV_W{1'b0}};
      end
    endcase
  end

  // Registered-output values, derived from the state about to be entered.
  // frame_done is set one edge ahead of the last cycle of the final stop bit.
  always_comb begin
    txd_d        = 1'b1;
    busy_d       = 1'b0;
    frame_done_d = 1'b0;
    case (state_d)
      S_IDLE:   txd_d = 1'b1;
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = data_d[bit_idx_d];
      S_PARITY: txd_d = even_parity(data_d);
      S_STOP:   txd_d = 1'b1;
      S_DSTOP:  txd_d = 1'b1;
`ifdef UART_TX_BREAK_EN
      S_BREAK:    txd_d = 1'b0;
      S_BRK_STOP: txd_d = 1'b1;
`endif
      default:  txd_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
    if (((state_d == S_STOP) && !dstop_d) || (state_d == S_DSTOP)) begin
      frame_done_d = (cnt_d == div_d);
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // State and output registers.
  // Reset is synchronous and active-low; it abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= {DIV_W{1'b0}};
      div_q        <= {DIV_W{1'b0}};
      bit_idx_q    <= 4'd0;
      len_q        <= 4'd0;
      data_q       <= 9'd0;
      par_en_q     <= 1'b0;
      dstop_q      <= 1'b0;
      txd_q        <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      len_q        <= len_d;
      data_q       <= data_d;
      par_en_q     <= par_en_d;
      dstop_q      <= dstop_d;
      txd_q        <= txd_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_ready   = tx_ready_s;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: directed, self-checking bench for uart_tx_framer.
// Expected line waveforms are hand-computed bit vectors.
// In each vector, bit i is the line level during bit period i, with the start bit at bit 0.
module tb_uart_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] divider;
  logic [4:0]  frame_len;
  logic        parity;
  logic        dstop;
  logic        flow_control;
  logic        cts_n;
  logic [8:0]  tx_data;
  logic        tx_valid;
`ifdef UART_TX_BREAK_EN
  logic        send_break;
`endif
  logic        tx_ready;
  logic        txd;
  logic        busy;
  logic        frame_done;

  int tests_run;
  int tests_failed;

  logic txd_log  [0:63];
  logic busy_log [0:63];
  logic done_log [0:63];
  logic rdy_log  [0:63];

  uart_tx_framer #(.DIV_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .divider      (divider),
    .frame_len    (frame_len),
    .parity       (parity),
    .dstop        (dstop),
    .flow_control (flow_control),
    .cts_n        (cts_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
`ifdef UART_TX_BREAK_EN
    .send_break   (send_break),
`endif
    .tx_ready     (tx_ready),
    .txd          (txd),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Change every latched input after acceptance; the frame in flight must not notice.
  task automatic scramble();
    tx_valid  = 1'b0;
    tx_data   = 9'h13C;
    divider   = 16'd7;
    frame_len = 5'd13;
    parity    = ~parity;
    dstop     = ~dstop;
    enable    = 1'b0;
  endtask

  // Record n cycles of outputs.
  // The first sample is taken in the current cycle.
  // tx_valid is dropped at index drop_at.
  task automatic capture(input int n, input int drop_at);
    for (int c = 0; c < n; c++) begin
      if (c > 0) step();
      if (c == drop_at) tx_valid = 1'b0;
      #1;
      txd_log[c]  = txd;
      busy_log[c] = busy;
      done_log[c] = frame_done;
      rdy_log[c]  = tx_ready;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; flow_control = 1'b0; cts_n = 1'b0;
    tx_valid = 1'b1; tx_data = 9'h0FF; divider = 16'd0; frame_len = 5'd8;
    parity = 1'b0; dstop = 1'b0;
    step(); step();
    tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); end
    tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd: got %b expected 1", txd); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    tx_valid = 1'b0;
    rst_n = 1'b1;
    step();
    tests_run++; if (busy !== 1'b0 || txd !== 1'b1) begin tests_failed++; $display("FAIL idle_after_reset: busy=%b txd=%b expected busy=0 txd=1", busy, txd); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_tx_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_frame_formats();
    logic [15:0] exp_bits;
    int nbits;
    int per;
    int total;
    for (int v = 0; v < 4; v++) begin
      case (v)
        0: begin divider = 16'd3; frame_len = 5'd8;  parity = 1'b0; dstop = 1'b0; tx_data = 9'h0A5; nbits = 10; exp_bits = 16'h034A; end
        1: begin divider = 16'd0; frame_len = 5'd7;  parity = 1'b1; dstop = 1'b1; tx_data = 9'h1FF; nbits = 11; exp_bits = 16'h07FE; end
        2: begin divider = 16'd1; frame_len = 5'd2;  parity = 1'b1; dstop = 1'b0; tx_data = 9'h0F3; nbits = 8;  exp_bits = 16'h00E6; end
        default: begin divider = 16'd0; frame_len = 5'd15; parity = 1'b0; dstop = 1'b1; tx_data = 9'h155; nbits = 12; exp_bits = 16'h0EAA; end
      endcase
      per   = int'(divider) + 1;
      total = nbits * per;
      enable = 1'b1; flow_control = 1'b0; tx_valid = 1'b1;
      #1;
      tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL fmt%0d_accept: tx_ready got %b expected 1", v, tx_ready); end
      step();
      scramble();
      capture(total + 1, -1);
      for (int c = 0; c < total; c++) begin
        tests_run++;
        if (txd_log[c] !== exp_bits[c / per] || busy_log[c] !== 1'b1 || done_log[c] !== (c == total - 1)) begin
          tests_failed++;
          $display("FAIL fmt%0d_cycle%0d: txd=%b busy=%b done=%b expected txd=%b busy=1 done=%b",
                   v, c + 1, txd_log[c], busy_log[c], done_log[c], exp_bits[c / per], (c == total - 1));
        end
      end
      tests_run++;
      if (txd_log[total] !== 1'b1 || busy_log[total] !== 1'b0 || done_log[total] !== 1'b0) begin
        tests_failed++;
        $display("FAIL fmt%0d_end_idle: txd=%b busy=%b done=%b expected 1 0 0", v, txd_log[total], busy_log[total], done_log[total]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic e_txd, e_busy, e_done, e_rdy;
    exp1 = 16'h006A;
    exp2 = 16'h0054;
    enable = 1'b1; flow_control = 1'b0; divider = 16'd1; frame_len = 5'd5;
    parity = 1'b0; dstop = 1'b0; tx_data = 9'h015; tx_valid = 1'b1;
    #1;
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept1: tx_ready got %b expected 1", tx_ready); end
    step();
    tx_data = 9'h00A;
    capture(30, 15);
    for (int c = 0; c < 30; c++) begin
      if (c < 14) begin
        e_txd = exp1[c / 2]; e_busy = 1'b1; e_done = (c == 13); e_rdy = 1'b0;
      end else if (c == 14) begin
        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
      end else if (c < 29) begin
        e_txd = exp2[(c - 15) / 2]; e_busy = 1'b1; e_done = (c == 28); e_rdy = 1'b0;
      end else begin
        e_txd = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_rdy = 1'b1;
      end
      tests_run++;
      if (txd_log[c] !== e_txd || busy_log[c] !== e_busy || done_log[c] !== e_done || rdy_log[c] !== e_rdy) begin
        tests_failed++;
        $display("FAIL b2b_cycle%0d: txd=%b busy=%b done=%b rdy=%b expected %b %b %b %b",
                 c + 1, txd_log[c], busy_log[c], done_log[c], rdy_log[c], e_txd, e_busy, e_done, e_rdy);
      end
    end
  endtask

  task automatic test_flow_control();
    logic [15:0] exp_bits;
    exp_bits = 16'h0066;
    enable = 1'b0; flow_control = 1'b0; cts_n = 1'b1; tx_valid = 1'b1;
    divider = 16'd0; frame_len = 5'd5; parity = 1'b0; dstop = 1'b0; tx_data = 9'h013;
    #1;
    tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL enable_low_ready: got %b expected 0", tx_ready); end
    enable = 1'b1; flow_control = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (tx_ready !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL cts_block%0d: tx_ready=%b txd=%b busy=%b expected 0 1 0", i, tx_ready, txd, busy);
      end
      step();
    end
    cts_n = 1'b0;
    #1;
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL cts_release_ready: got %b expected 1", tx_ready); end
    step();
    tx_valid = 1'b0;
    cts_n = 1'b1;
    capture(8, -1);
    for (int c = 0; c < 7; c++) begin
      tests_run++;
      if (txd_log[c] !== exp_bits[c] || busy_log[c] !== 1'b1 || done_log[c] !== (c == 6)) begin
        tests_failed++;
        $display("FAIL flow_cycle%0d: txd=%b busy=%b done=%b expected txd=%b busy=1 done=%b",
                 c + 1, txd_log[c], busy_log[c], done_log[c], exp_bits[c], (c == 6));
      end
    end
    tests_run++;
    if (busy_log[7] !== 1'b0 || txd_log[7] !== 1'b1 || rdy_log[7] !== 1'b0) begin
      tests_failed++;
      $display("FAIL flow_end: busy=%b txd=%b rdy=%b expected 0 1 0", busy_log[7], txd_log[7], rdy_log[7]);
    end
    flow_control = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1; flow_control = 1'b0; divider = 16'd1; frame_len = 5'd8;
    parity = 1'b0; dstop = 1'b0; tx_data = 9'h000; tx_valid = 1'b1;
    #1;
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_accept: tx_ready got %b expected 1", tx_ready); end
    step();
    tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    tests_run++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_in_d4: txd=%b busy=%b expected 0 1", txd, busy);
    end
    rst_n = 1'b0;
    step();
    tests_run++;
    if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || tx_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_abort: txd=%b busy=%b done=%b rdy=%b expected 1 0 0 0", txd, busy, frame_done, tx_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      tests_run++;
      if (frame_done !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_quiet%0d: done=%b txd=%b busy=%b expected 0 1 0", i, frame_done, txd, busy);
      end
    end
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic e_txd, e_busy, e_rdy;
    enable = 1'b1; flow_control = 1'b0; divider = 16'd2; tx_valid = 1'b1; send_break = 1'b1;
    #1;
    tests_run++; if (tx_ready !== 1'b0) begin tests_failed++; $display("FAIL break_ready: got %b expected 0", tx_ready); end
    for (int c = 1; c <= 25; c++) begin
      step();
      tx_valid = 1'b0;
      if (c == 20) send_break = 1'b0;
      #1;
      e_txd  = (c > 20);
      e_busy = (c <= 23);
      e_rdy  = (c >= 24);
      tests_run++;
      if (txd !== e_txd || busy !== e_busy || tx_ready !== e_rdy) begin
        tests_failed++;
        $display("FAIL break_cycle%0d: txd=%b busy=%b rdy=%b expected %b %b %b", c, txd, busy, tx_ready, e_txd, e_busy, e_rdy);
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
`endif
    test_reset();
    test_frame_formats();
    test_back_to_back();
    test_flow_control();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
